mmt_sync_filter_multi: RTL and testbench

//   Multi-channel synchroniser for slow asynchronous level inputs such as straps, GPIO and status lines.

---
 rtl/mmt_sync_pkg.sv | 41 ++++
 rtl/mmt_sync_filter_ch.sv | 122 ++++++++++++
 rtl/mmt_sync_filter_multi.sv | 54 +++++
 tb/tb_mmt_sync_filter_multi.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmt_sync_pkg.sv
// Shared helpers for the mmt_sync_filter family: width math, reset-value expansion and
// simulation-only fault-injection switches.
package mmt_sync_pkg;

  localparam int MAX_DEPTH = 32;

`ifdef INJECT_DELAY
  localparam bit INJ_DELAY_EN = 1'b1;
`else
  localparam bit INJ_DELAY_EN = 1'b0;
`endif

`ifdef INJECT_X
  localparam bit INJ_X_EN = 1'b1;
`else
  localparam bit INJ_X_EN = 1'b0;
`endif

  function automatic int clog2(input int v);
    int r;
    int one;
    r   = 0;
    one = 1;
    while ((one << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Counter must hold 0..N-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [MAX_DEPTH-1:0] chain_rst(input logic v);
    return {MAX_DEPTH{v}};
  endfunction

endpackage

// File: rtl/mmt_sync_filter_ch.sv
// One channel: Depth-flop synchroniser, optional persistence filter and registered edge flags.
module mmt_sync_filter_ch
  import mmt_sync_pkg::*;
#(
  parameter int   Depth        = 3,
  parameter logic ResetVal     = 1'b0,
  parameter int   FilterCycles = 4,
  parameter int   CntW         = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  input  logic hold,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic chg_nxt
);

  localparam logic [MAX_DEPTH-1:0] RST_FULL  = chain_rst(ResetVal);
  localparam logic [Depth-1:0]     RST_CHAIN = RST_FULL[Depth-1:0];

  logic             x_in_s;
  logic             chain_in_s;
  logic [Depth-1:0] sync_r;
  logic             s_s;
  logic             out_r;
  logic             out_nxt_s;
  logic             rise_r;
  logic             fall_r;
  logic             rise_nxt_s;
  logic             fall_nxt_s;

  generate
    if (INJ_X_EN) begin : g_injx
      logic first_r;
      // Flags the first cycle after reset so the chain input can be poisoned.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) first_r <= 1'b1;
        else       first_r <= 1'b0;
      end
      assign x_in_s = first_r ? 1'bx : din;
    end else begin : g_nox
      assign x_in_s = din;
    end

    if (INJ_DELAY_EN) begin : g_injd
      logic dly_r;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) dly_r <= ResetVal;
        else       dly_r <= x_in_s;
      end
      assign chain_in_s = dly_r;
    end else begin : g_nodly
      assign chain_in_s = x_in_s;
    end
  endgenerate

  // Synchroniser chain; bit 0 is the metastability-capturing flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_r <= RST_CHAIN;
    else       sync_r <= {sync_r[Depth-2:0], chain_in_s};
  end

  assign s_s = sync_r[Depth-1];

  generate
    if (FilterCycles > 0) begin : g_filt
      localparam logic [CntW-1:0] CNT_MAX = CntW'(FilterCycles - 1);
      logic [CntW-1:0] cnt_r;
      logic [CntW-1:0] cnt_nxt_s;

      // A new level is accepted only after it has disagreed with out for N straight cycles.
      always_comb begin
        out_nxt_s = out_r;
        cnt_nxt_s = {CntW{1'b0}};
        if (hold) begin
          out_nxt_s = out_r;
          cnt_nxt_s = {CntW{1'b0}};
        end else if (s_s != out_r) begin
          if (cnt_r == CNT_MAX) begin
            out_nxt_s = s_s;
            cnt_nxt_s = {CntW{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + CntW'(1);
          end
        end else begin
          cnt_nxt_s = {CntW{1'b0}};
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_r <= {CntW{1'b0}};
        else       cnt_r <= cnt_nxt_s;
      end
    end else begin : g_byp
      assign out_nxt_s = hold ? out_r : s_s;
    end
  endgenerate

  assign rise_nxt_s = out_nxt_s & ~out_r;
  assign fall_nxt_s = ~out_nxt_s & out_r;

  // Level and edge flags register together so pulses align with the level change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_r  <= ResetVal;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      out_r  <= out_nxt_s;
      rise_r <= rise_nxt_s;
      fall_r <= fall_nxt_s;
    end
  end

  assign dout    = out_r;
  assign rise    = rise_r;
  assign fall    = fall_r;
  assign chg_nxt = rise_nxt_s | fall_nxt_s;

endmodule

// File: rtl/mmt_sync_filter_multi.sv
// Multi-channel synchroniser/debouncer for slow asynchronous levels, with per-channel
// rise/fall pulses and an any-change flag aligned to them.
module mmt_sync_filter_multi
  import mmt_sync_pkg::*;
#(
  parameter int               Width        = 4,
  parameter int               Depth        = 3,
  parameter logic [Width-1:0] ResetVal     = {Width{1'b0}},
  parameter int               FilterCycles = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [Width-1:0] in,
  input  logic             hold,
  output logic [Width-1:0] out,
  output logic [Width-1:0] rise,
  output logic [Width-1:0] fall,
  output logic             chg_any
);

  localparam int CntW = cnt_width(FilterCycles);

  logic [Width-1:0] chg_nxt_s;
  logic             chg_any_r;

  generate
    for (genvar i = 0; i < Width; i++) begin : g_ch
      mmt_sync_filter_ch #(
        .Depth        (Depth),
        .ResetVal     (ResetVal[i]),
        .FilterCycles (FilterCycles),
        .CntW         (CntW)
      ) u_ch (
        .clk     (clk),
        .rstn    (rstn),
        .din     (in[i]),
        .hold    (hold),
        .dout    (out[i]),
        .rise    (rise[i]),
        .fall    (fall[i]),
        .chg_nxt (chg_nxt_s[i])
      );
    end
  endgenerate

  // Built from the channels' next-edge terms so it lands in the same cycle as rise/fall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) chg_any_r <= 1'b0;
    else       chg_any_r <= |chg_nxt_s;
  end

  assign chg_any = chg_any_r;

endmodule

// File: tb/tb_mmt_sync_filter_multi.sv
// Self-checking bench: reset table, hand-written corner sequences and a randomized soak,
// all compared against a sliding-window reference model of the filter.
module tb_mmt_sync_filter_multi;

  localparam int         W  = 4;
  localparam int         D  = 3;
  localparam int         N  = 4;
  localparam logic [3:0] RV = 4'b0101;
  localparam int         HN = 16384;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] din  = 4'b1010;
  logic       hold = 1'b0;

  logic [3:0] out_f, rise_f, fall_f;
  logic       chg_f;
  logic [3:0] out_b, rise_b, fall_b;
  logic       chg_b;

  int checks = 0;
  int errors = 0;

  // Reference model state: input/hold history since reset, plus expected outputs.
  int         e;
  logic [3:0] in_h   [0:HN-1];
  logic       hold_h [0:HN-1];
  logic [3:0] m_out, m_rise, m_fall;
  logic       m_chg;
  logic [3:0] b_out, b_rise, b_fall;
  logic       b_chg;

  always #5 clk = ~clk;

  mmt_sync_filter_multi #(
    .Width(W), .Depth(D), .ResetVal(RV), .FilterCycles(N)
  ) dut (
    .clk(clk), .rstn(rstn), .in(din), .hold(hold),
    .out(out_f), .rise(rise_f), .fall(fall_f), .chg_any(chg_f)
  );

  mmt_sync_filter_multi #(
    .Width(W), .Depth(D), .ResetVal(4'b0000), .FilterCycles(0)
  ) dut_byp (
    .clk(clk), .rstn(rstn), .in(din), .hold(hold),
    .out(out_b), .rise(rise_b), .fall(fall_b), .chg_any(chg_b)
  );

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronised level seen by the filter at edge k: the input sampled D edges earlier.
  function automatic logic [3:0] s_at(input int k, input logic [3:0] rv);
    if (k - D >= 1) return in_h[k-D];
    else            return rv;
  endfunction

  task automatic model_reset();
    e      = 0;
    m_out  = RV;      m_rise = 4'b0000; m_fall = 4'b0000; m_chg = 1'b0;
    b_out  = 4'b0000; b_rise = 4'b0000; b_fall = 4'b0000; b_chg = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] nf, nb, sv;
    logic       ok;
    e = e + 1;
    in_h[e]   = din;
    hold_h[e] = hold;
    nf = m_out;
    nb = b_out;
    for (int i = 0; i < W; i++) begin
      ok = 1'b1;
      for (int j = 0; j < N; j++) begin
        sv = s_at(e - j, RV);
        if ((e - j) < 1 || hold_h[e-j] || sv[i] == m_out[i]) ok = 1'b0;
      end
      if (ok) nf[i] = ~m_out[i];
    end
    if (!hold) nb = s_at(e, 4'b0000);
    m_rise = nf & ~m_out;  m_fall = ~nf & m_out;  m_chg = |(m_rise | m_fall);  m_out = nf;
    b_rise = nb & ~b_out;  b_fall = ~nb & b_out;  b_chg = |(b_rise | b_fall);  b_out = nb;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_out"},   out_f,          m_out);
    chk({tag, "_rise"},  rise_f,         m_rise);
    chk({tag, "_fall"},  fall_f,         m_fall);
    chk({tag, "_chg"},   {3'b000, chg_f}, {3'b000, m_chg});
    chk({tag, "_bout"},  out_b,          b_out);
    chk({tag, "_brise"}, rise_b,         b_rise);
    chk({tag, "_bfall"}, fall_b,         b_fall);
    chk({tag, "_bchg"},  {3'b000, chg_b}, {3'b000, b_chg});
  endtask

  task automatic step(input logic [3:0] iv, input logic hv);
    din  = iv;
    hold = hv;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all("mdl");
  endtask

  task automatic settle(input logic [3:0] iv);
    for (int k = 0; k < 10; k++) step(iv, 1'b0);
  endtask

  task automatic do_reset(input int cyc);
    rstn = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    for (int k = 0; k < cyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      compare_all("rsthold");
    end
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [3:0] iv;
    logic       hv;
    logic [3:0] eo, er, ef;
    logic       ec;
    logic [3:0] ebo, ebr;
    logic       ebc;
  } vec_t;

  vec_t       tbl [10];
  logic [3:0] cur, pr_f, pf_f, pr_b, pf_b;

  initial begin
    // Reset release with in differing from ResetVal: one filtered step after Depth+N edges.
    tbl[0] = '{4'b1010, 1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[1] = '{4'b1010, 1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[2] = '{4'b1010, 1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[3] = '{4'b1010, 1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b1010, 1'b1};
    tbl[4] = '{4'b1010, 1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 1'b0};
    tbl[5] = '{4'b1010, 1'b0, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 1'b0};
    tbl[6] = '{4'b1010, 1'b0, 4'b1010, 4'b1010, 4'b0101, 1'b1, 4'b1010, 4'b0000, 1'b0};
    tbl[7] = '{4'b1010, 1'b0, 4'b1010, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 1'b0};
    tbl[8] = '{4'b1010, 1'b0, 4'b1010, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 1'b0};
    tbl[9] = '{4'b1010, 1'b0, 4'b1010, 4'b0000, 4'b0000, 1'b0, 4'b1010, 4'b0000, 1'b0};

    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_out",  out_f,  RV);
    chk("reset_rise", rise_f, 4'b0000);
    chk("reset_fall", fall_f, 4'b0000);
    chk("reset_chg",  {3'b000, chg_f}, 4'b0000);
    chk("reset_bout", out_b,  4'b0000);
    rstn = 1'b1;

    for (int t = 0; t < 10; t++) begin
      step(tbl[t].iv, tbl[t].hv);
      chk("vec_out",   out_f,  tbl[t].eo);
      chk("vec_rise",  rise_f, tbl[t].er);
      chk("vec_fall",  fall_f, tbl[t].ef);
      chk("vec_chg",   {3'b000, chg_f}, {3'b000, tbl[t].ec});
      chk("vec_bout",  out_b,  tbl[t].ebo);
      chk("vec_brise", rise_b, tbl[t].ebr);
      chk("vec_bchg",  {3'b000, chg_b}, {3'b000, tbl[t].ebc});
    end

    // Glitch of N-1 cycles is swallowed.
    for (int t = 0; t < 13; t++) begin
      step((t < 3) ? 4'b1011 : 4'b1010, 1'b0);
      chk("glitch_out",  out_f,  4'b1010);
      chk("glitch_rise", rise_f, 4'b0000);
    end
    // N-cycle pulse passes after Depth+N.
    for (int t = 1; t <= 14; t++) begin
      step((t <= 4) ? 4'b1011 : 4'b1010, 1'b0);
      if (t == 6) chk("pulse_pre_out", out_f, 4'b1010);
      if (t == 7) begin
        chk("pulse_out",  out_f,  4'b1011);
        chk("pulse_rise", rise_f, 4'b0001);
        chk("pulse_chg",  {3'b000, chg_f}, 4'b0001);
      end
      if (t == 8) chk("pulse_rise_w", rise_f, 4'b0000);
    end

    // Bypass instance: Depth+1 latency, rise and chg_any together.
    for (int t = 1; t <= 8; t++) begin
      step(4'b1110, 1'b0);
      if (t == 3) chk("byp_pre_out", out_b, 4'b1010);
      if (t == 4) begin
        chk("byp_out",  out_b,  4'b1110);
        chk("byp_rise", rise_b, 4'b0100);
        chk("byp_chg",  {3'b000, chg_b}, 4'b0001);
      end
    end

    // Hold freezes out and restarts the count on release.
    settle(4'b1100);
    for (int t = 0; t < 10; t++) begin
      step(4'b1110, 1'b1);
      chk("hold_out",  out_f,  4'b1100);
      chk("hold_rise", rise_f, 4'b0000);
      chk("hold_chg",  {3'b000, chg_f}, 4'b0000);
    end
    for (int t = 1; t <= 6; t++) begin
      step(4'b1110, 1'b0);
      if (t == 3) chk("unhold_pre_out", out_f, 4'b1100);
      if (t == 4) begin
        chk("unhold_out",  out_f,  4'b1110);
        chk("unhold_rise", rise_f, 4'b0010);
      end
    end

    // Reset in the middle of a count.
    settle(4'b0000);
    for (int t = 0; t < 5; t++) step(4'b1000, 1'b0);
    do_reset(2);
    chk("midrst_out",  out_f,  RV);
    chk("midrst_rise", rise_f, 4'b0000);
    chk("midrst_fall", fall_f, 4'b0000);
    for (int t = 1; t <= 8; t++) begin
      step(4'b1000, 1'b0);
      if (t == 6) chk("midrst_pre_out", out_f, 4'b0101);
      if (t == 7) begin
        chk("midrst_post_out",  out_f,  4'b1000);
        chk("midrst_post_rise", rise_f, 4'b1000);
        chk("midrst_post_fall", fall_f, 4'b0101);
      end
    end

    // All channels step together.
    settle(4'b0000);
    for (int t = 1; t <= 8; t++) begin
      step(4'b1111, 1'b0);
      if (t == 6) chk("multi_pre_rise", rise_f, 4'b0000);
      if (t == 7) begin
        chk("multi_rise", rise_f, 4'b1111);
        chk("multi_fall", fall_f, 4'b0000);
        chk("multi_chg",  {3'b000, chg_f}, 4'b0001);
      end
      if (t == 8) chk("multi_chg_w", {3'b000, chg_f}, 4'b0000);
    end

    // Every-cycle toggling never reaches a filtered output.
    settle(4'b0000);
    for (int t = 0; t < 20; t++) begin
      step((t % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0);
      chk("toggle_out", out_f, 4'b0000);
    end

    // Randomized jitter soak with occasional hold and reset.
    cur  = 4'b0000;
    pr_f = 4'b0000; pf_f = 4'b0000; pr_b = 4'b0000; pf_b = 4'b0000;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
        pr_f = 4'b0000; pf_f = 4'b0000; pr_b = 4'b0000; pf_b = 4'b0000;
      end
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 3) == 0) cur[b] = ~cur[b];
      end
      step(cur, ($urandom_range(0, 15) == 0));
      chk("pw_rise",  pr_f & rise_f, 4'b0000);
      chk("pw_fall",  pf_f & fall_f, 4'b0000);
      chk("pw_brise", pr_b & rise_b, 4'b0000);
      chk("pw_bfall", pf_b & fall_b, 4'b0000);
      pr_f = rise_f; pf_f = fall_f; pr_b = rise_b; pf_b = fall_b;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
